scrambler_tx_sched: RTL and testbench

//  TX frame scheduler in front of the 116-bit 1+X13+X33 scrambler.
//  - Arbitrates between a user data stream and a control-frame stream.
//  - Inserts idle frames when neither stream has a frame.
//  - Sends an init burst of idles after reset so the far-end descrambler self-syncs.
//  - Drives the scrambler's data_in/valid_in and the unscrambled 2-bit sync header, gated by gearbox back-pressure.

---
 rtl/scrambler_tx_sched.sv | 142 ++++++++++++++
 tb/tb_scrambler_tx_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scrambler_tx_sched.sv
// ---------------------------------------------------------------------------
// scrambler_tx_sched
// TX frame scheduler that sits in front of the 1+X13+X33 payload scrambler.
// It arbitrates between a user data stream and a control-frame stream,
// inserts idle frames when neither stream has a frame, and sends a burst of
// idles after reset so the far-end descrambler can self-synchronise.
// The chosen frame is held in a single output register stage that only
// advances when the gearbox is not pausing.
//
// Ports
//   clk, rst        clock; synchronous active-high reset (also resets scrambler)
//   data_tdata/tvalid/tready   user payload stream
//   ctl_tdata/tvalid/tready    control payload stream
//   gb_pause        gearbox cannot take a frame this cycle
//   scr_data_in     registered payload to the scrambler
//   scr_valid_in    scrambler advance/consume strobe
//   frame_hdr       sync header: 2'b01 data, 2'b10 control/idle
//   frame_is_idle   current output frame is an idle insert
//   init_done       high once the post-reset idle burst has been sent
// ---------------------------------------------------------------------------
module scrambler_tx_sched #(
    parameter int                DATA_W        = 116,
    parameter int                INIT_IDLES    = 16,
    parameter int                MAX_CTL_BURST = 4,
    parameter logic [DATA_W-1:0] IDLE_WORD     = {58{2'b10}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_tdata,
    input  logic              data_tvalid,
    output logic              data_tready,
    input  logic [DATA_W-1:0] ctl_tdata,
    input  logic              ctl_tvalid,
    output logic              ctl_tready,
    input  logic              gb_pause,
    output logic [DATA_W-1:0] scr_data_in,
    output logic              scr_valid_in,
    output logic [1:0]        frame_hdr,
    output logic              frame_is_idle,
    output logic              init_done
);

    localparam logic [7:0] INIT_LAST = 8'(INIT_IDLES - 1);
    localparam logic [3:0] BURST_MAX = 4'(MAX_CTL_BURST);
    localparam logic [1:0] HDR_DATA  = 2'b01;
    localparam logic [1:0] HDR_CTL   = 2'b10;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            state_q;
    logic [7:0]        init_cnt_q;
    logic [3:0]        burst_cnt_q;
    logic              ovalid_q;
    logic [DATA_W-1:0] scr_data_q;
    logic [1:0]        hdr_q;
    logic              idle_q;
    logic              init_done_q;

    logic              load;
    logic              run_load;
    logic              grant_ctl;
    logic              grant_data;
    logic [DATA_W-1:0] frame_data_d;
    logic [1:0]        frame_hdr_d;
    logic              frame_idle_d;

    // An empty output stage always accepts; a full one only when the gearbox
    // drains it this cycle, so consume and reload happen together.
    assign load     = ~ovalid_q | ~gb_pause;
    assign run_load = load & (state_q == ST_RUN) & ~rst;

    // Control wins unless data is waiting and control has used its burst.
    assign grant_ctl  = ctl_tvalid & (~data_tvalid | (burst_cnt_q < BURST_MAX));
    assign grant_data = data_tvalid & ~grant_ctl;

    assign data_tready = run_load & grant_data;
    assign ctl_tready  = run_load & grant_ctl;

    always_comb begin
        frame_data_d = IDLE_WORD;
        frame_hdr_d  = HDR_CTL;
        frame_idle_d = 1'b1;
        if (grant_ctl) begin
            frame_data_d = ctl_tdata;
            frame_idle_d = 1'b0;
        end else if (grant_data) begin
            frame_data_d = data_tdata;
            frame_hdr_d  = HDR_DATA;
            frame_idle_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            burst_cnt_q <= '0;
            ovalid_q    <= 1'b0;
            scr_data_q  <= '0;
            hdr_q       <= 2'b00;
            idle_q      <= 1'b0;
            init_done_q <= 1'b0;
        end else if (load) begin
            ovalid_q <= 1'b1;
            case (state_q)
                ST_INIT: begin
                    scr_data_q <= IDLE_WORD;
                    hdr_q      <= HDR_CTL;
                    idle_q     <= 1'b1;
                    init_cnt_q <= init_cnt_q + 8'd1;
                    if (init_cnt_q == INIT_LAST) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    scr_data_q  <= frame_data_d;
                    hdr_q       <= frame_hdr_d;
                    idle_q      <= frame_idle_d;
                    init_done_q <= 1'b1;
                    // A control grant with data waiting is below BURST_MAX,
                    // so the increment saturates naturally at BURST_MAX.
                    if (grant_ctl && data_tvalid) begin
                        burst_cnt_q <= burst_cnt_q + 4'd1;
                    end else begin
                        burst_cnt_q <= '0;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign scr_data_in   = scr_data_q;
    assign frame_hdr     = hdr_q;
    assign frame_is_idle = idle_q;
    assign init_done     = init_done_q;
    assign scr_valid_in  = ovalid_q & ~gb_pause;

endmodule

// File: tb/tb_scrambler_tx_sched.sv
module tb_scrambler_tx_sched;

    localparam int W = 116;

    logic         clk;
    logic         rst;
    logic [W-1:0] data_tdata;
    logic         data_tvalid;
    logic         data_tready;
    logic [W-1:0] ctl_tdata;
    logic         ctl_tvalid;
    logic         ctl_tready;
    logic         gb_pause;
    logic [W-1:0] scr_data_in;
    logic         scr_valid_in;
    logic [1:0]   frame_hdr;
    logic         frame_is_idle;
    logic         init_done;

    logic [W-1:0] idle_word;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   h;
    } frm_t;
    frm_t mon_q[$];
    bit   mon_en = 0;

    scrambler_tx_sched dut (
        .clk          (clk),
        .rst          (rst),
        .data_tdata   (data_tdata),
        .data_tvalid  (data_tvalid),
        .data_tready  (data_tready),
        .ctl_tdata    (ctl_tdata),
        .ctl_tvalid   (ctl_tvalid),
        .ctl_tready   (ctl_tready),
        .gb_pause     (gb_pause),
        .scr_data_in  (scr_data_in),
        .scr_valid_in (scr_valid_in),
        .frame_hdr    (frame_hdr),
        .frame_is_idle(frame_is_idle),
        .init_done    (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frames actually consumed by the scrambler.
    always @(negedge clk) begin
        if (mon_en && scr_valid_in === 1'b1) mon_q.push_back('{scr_data_in, frame_hdr});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] dword(input int i);
        return {4'hD, 80'h0, 32'(i)};
    endfunction

    function automatic logic [W-1:0] cword(input int i);
        return {4'hC, 80'h5A5A, 32'(i)};
    endfunction

    // 1+X13+X33 self-synchronising scrambler / descrambler, LSB first.
    task automatic scramble(input logic [W-1:0] d, input logic [57:0] st_i,
                            output logic [W-1:0] s, output logic [57:0] st_o);
        logic [57:0] st;
        st = st_i;
        for (int b = 0; b < W; b++) begin
            s[b] = d[b] ^ st[12] ^ st[32];
            st   = {st[56:0], s[b]};
        end
        st_o = st;
    endtask

    task automatic descramble(input logic [W-1:0] s, input logic [57:0] st_i,
                              output logic [W-1:0] d, output logic [57:0] st_o);
        logic [57:0] st;
        st = st_i;
        for (int b = 0; b < W; b++) begin
            d[b] = s[b] ^ st[12] ^ st[32];
            st   = {st[56:0], s[b]};
        end
        st_o = st;
    endtask

    task automatic test_reset;
        rst = 1'b1; data_tvalid = 1'b1; ctl_tvalid = 1'b1; gb_pause = 1'b0;
        data_tdata = dword(0); ctl_tdata = cword(0);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({scr_valid_in, scr_data_in, frame_hdr, frame_is_idle, init_done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b hdr=%b idle=%b done=%b data=%h, required all zero",
                     scr_valid_in, frame_hdr, frame_is_idle, init_done, scr_data_in);
        end
        checks++;
        if ({data_tready, ctl_tready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready: data_tready=%b ctl_tready=%b, required 0 0", data_tready, ctl_tready);
        end
        @(posedge clk); #1;
        rst = 1'b0; data_tvalid = 1'b0; ctl_tvalid = 1'b0;
    endtask

    task automatic test_init;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (scr_valid_in !== 1'b1 || frame_hdr !== 2'b10 || frame_is_idle !== 1'b1 ||
                scr_data_in !== idle_word || data_tready !== 1'b0 || ctl_tready !== 1'b0) begin
                failures++;
                $display("FAIL init_idle[%0d]: valid=%b hdr=%b idle=%b rdy=%b%b data=%h, required idle frame no ready",
                         k, scr_valid_in, frame_hdr, frame_is_idle, data_tready, ctl_tready, scr_data_in);
            end
            checks++;
            if (init_done !== (k == 17)) begin
                failures++;
                $display("FAIL init_done[%0d]: got %b, required %b", k, init_done, (k == 17));
            end
        end
    endtask

    task automatic test_data_stream;
        @(posedge clk); #1;
        data_tvalid = 1'b1; data_tdata = dword(0);
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (scr_data_in !== dword(i - 1) || frame_hdr !== 2'b01 || frame_is_idle !== 1'b0) begin
                    failures++;
                    $display("FAIL data_frame[%0d]: data=%h hdr=%b idle=%b, required %h 01 0",
                             i - 1, scr_data_in, frame_hdr, frame_is_idle, dword(i - 1));
                end
            end
            checks++;
            if (data_tready !== (i < 8)) begin
                failures++;
                $display("FAIL data_ready[%0d]: got %b, required %b", i, data_tready, (i < 8));
            end
            @(posedge clk); #1;
            if (i < 7) data_tdata = dword(i + 1);
            else data_tvalid = 1'b0;
        end
    endtask

    task automatic test_arbitration;
        int cn, dn;
        bit exp_c, prev_c;
        logic [W-1:0] prev_d;
        cn = 0; dn = 0; prev_c = 0; prev_d = '0;
        ctl_tvalid = 1'b1; data_tvalid = 1'b1;
        ctl_tdata = cword(0); data_tdata = dword(50);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (scr_data_in !== prev_d || frame_hdr !== (prev_c ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL arb_frame[%0d]: data=%h hdr=%b, required %h %b",
                             k - 1, scr_data_in, frame_hdr, prev_d, (prev_c ? 2'b10 : 2'b01));
                end
            end
            if (k < 10) begin
                exp_c = (k % 5) != 4;
                checks++;
                if (ctl_tready !== exp_c || data_tready !== !exp_c) begin
                    failures++;
                    $display("FAIL arb_grant[%0d]: ctl_tready=%b data_tready=%b, required %b %b",
                             k, ctl_tready, data_tready, exp_c, !exp_c);
                end
                prev_c = exp_c;
                prev_d = exp_c ? cword(cn) : dword(50 + dn);
                @(posedge clk); #1;
                if (exp_c) begin cn++; ctl_tdata = cword(cn); end
                else begin dn++; data_tdata = dword(50 + dn); end
            end
        end
        @(posedge clk); #1;
        ctl_tvalid = 1'b0; data_tvalid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ctl_only;
        bit exp_c;
        ctl_tvalid = 1'b1; data_tvalid = 1'b0; ctl_tdata = cword(200);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (ctl_tready !== 1'b1 || data_tready !== 1'b0) begin
                failures++;
                $display("FAIL ctl_only[%0d]: ctl_tready=%b data_tready=%b, required 1 0", k, ctl_tready, data_tready);
            end
            @(posedge clk); #1;
            ctl_tdata = cword(201 + k);
        end
        // burst count must still be 0, so four control grants precede data
        data_tvalid = 1'b1; data_tdata = dword(300);
        for (int k = 0; k < 5; k++) begin
            exp_c = (k != 4);
            @(negedge clk);
            checks++;
            if (ctl_tready !== exp_c || data_tready !== !exp_c) begin
                failures++;
                $display("FAIL ctl_then_data[%0d]: ctl_tready=%b data_tready=%b, required %b %b",
                         k, ctl_tready, data_tready, exp_c, !exp_c);
            end
            @(posedge clk); #1;
        end
        ctl_tvalid = 1'b0; data_tvalid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_pause;
        int sent, nd;
        bit hand;
        logic [W-1:0] held, s, dd;
        logic [57:0] st_s, st_d;
        mon_q.delete();
        mon_en = 1;
        sent = 0; held = '0;
        data_tvalid = 1'b1; data_tdata = dword(100);
        for (int cyc = 0; cyc < 15; cyc++) begin
            gb_pause = (cyc >= 3 && cyc <= 5);
            @(negedge clk);
            if (gb_pause) begin
                if (cyc == 3) begin
                    held = scr_data_in;
                    checks++;
                    if (held !== dword(102)) begin
                        failures++;
                        $display("FAIL pause_held: data=%h, required %h", held, dword(102));
                    end
                end
                checks++;
                if (scr_valid_in !== 1'b0 || data_tready !== 1'b0 || ctl_tready !== 1'b0 ||
                    scr_data_in !== held || frame_hdr !== 2'b01) begin
                    failures++;
                    $display("FAIL pause_hold[%0d]: valid=%b rdy=%b data=%h hdr=%b, required 0 0 %h 01",
                             cyc, scr_valid_in, data_tready, scr_data_in, frame_hdr, held);
                end
            end
            hand = data_tready;
            @(posedge clk); #1;
            if (hand) begin
                sent++;
                if (sent < 6) data_tdata = dword(100 + sent);
                else data_tvalid = 1'b0;
            end
        end
        gb_pause = 1'b0;
        @(posedge clk); #1;
        mon_en = 0;
        nd = 0;
        foreach (mon_q[j]) begin
            if (mon_q[j].h == 2'b01) begin
                checks++;
                if (mon_q[j].d !== dword(100 + nd)) begin
                    failures++;
                    $display("FAIL pause_order[%0d]: data=%h, required %h", nd, mon_q[j].d, dword(100 + nd));
                end
                nd++;
            end
        end
        checks++;
        if (nd != 6) begin
            failures++;
            $display("FAIL pause_count: consumed data frames=%0d, required 6", nd);
        end
        // Scramble what was consumed and recover it with an unsynchronised
        // descrambler; after the first frame the payloads must line up.
        st_s = '0; st_d = 58'h2AB_CDEF_0123_4567;
        nd = 0;
        foreach (mon_q[j]) begin
            scramble(mon_q[j].d, st_s, s, st_s);
            descramble(s, st_d, dd, st_d);
            if (j > 0 && mon_q[j].h == 2'b01) begin
                checks++;
                if (dd !== dword(100 + nd)) begin
                    failures++;
                    $display("FAIL descramble[%0d]: data=%h, required %h", j, dd, dword(100 + nd));
                end
            end
            if (mon_q[j].h == 2'b01) nd++;
        end
    endtask

    task automatic test_reset_mid_burst;
        ctl_tvalid = 1'b1; data_tvalid = 1'b1;
        ctl_tdata = cword(400); data_tdata = dword(400);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (ctl_tready !== 1'b1) begin
                failures++;
                $display("FAIL burst_pre[%0d]: ctl_tready=%b, required 1", k, ctl_tready);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({data_tready, ctl_tready} !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset_ready: data_tready=%b ctl_tready=%b, required 0 0", data_tready, ctl_tready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({scr_valid_in, scr_data_in, frame_hdr, frame_is_idle, init_done, data_tready, ctl_tready} !== '0) begin
            failures++;
            $display("FAIL mid_reset_state: valid=%b hdr=%b idle=%b done=%b rdy=%b%b data=%h, required all zero",
                     scr_valid_in, frame_hdr, frame_is_idle, init_done, data_tready, ctl_tready, scr_data_in);
        end
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (scr_valid_in !== 1'b1 || frame_is_idle !== 1'b1 || frame_hdr !== 2'b10 ||
                scr_data_in !== idle_word || init_done !== 1'b0) begin
                failures++;
                $display("FAIL reinit_idle[%0d]: valid=%b idle=%b hdr=%b done=%b, required 1 1 10 0",
                         k, scr_valid_in, frame_is_idle, frame_hdr, init_done);
            end
            checks++;
            if (ctl_tready !== (k == 16) || data_tready !== 1'b0) begin
                failures++;
                $display("FAIL reinit_ready[%0d]: ctl_tready=%b data_tready=%b, required %b 0",
                         k, ctl_tready, data_tready, (k == 16));
            end
        end
        @(posedge clk); #1;
        ctl_tvalid = 1'b0; data_tvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (scr_data_in !== cword(400) || frame_hdr !== 2'b10 || init_done !== 1'b1) begin
            failures++;
            $display("FAIL reinit_first: data=%h hdr=%b done=%b, required %h 10 1",
                     scr_data_in, frame_hdr, init_done, cword(400));
        end
    endtask

    initial begin
        idle_word = {58{2'b10}};
        rst = 1'b1; gb_pause = 1'b0;
        data_tvalid = 1'b0; ctl_tvalid = 1'b0;
        data_tdata = '0; ctl_tdata = '0;
        test_reset();
        test_init();
        test_data_stream();
        test_arbitration();
        test_ctl_only();
        test_pause();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
